latch_bank: RTL and testbench

LATCH_BANK -- requirements
Module: latch_bank

---
 rtl/latch_bank_pkg.sv | 12 +
 rtl/latch_bank_cell.sv | 27 ++
 rtl/latch_bank.sv | 122 ++++++++++++
 tb/tb_latch_bank.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/latch_bank_pkg.sv
// Shared types and default sizing for the latch_bank channel store.
package latch_bank_pkg;

    localparam int unsigned DefWidth = 8;
    localparam int unsigned DefNch   = 4;

    typedef enum logic {
        StIdle,
        StClear
    } state_e;

endpackage

// File: rtl/latch_bank_cell.sv
// One WIDTH-bit storage channel: sync reset, then clear, then load, in priority order.
module latch_bank_cell #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] val_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= '0;
        end else if (clr) begin
            val_q <= '0;
        end else if (ld) begin
            val_q <= d;
        end
    end

    assign q = val_q;

endmodule

// File: rtl/latch_bank.sv
// Multi-channel register bank with sticky change flags and a sequential clear sweep.
// Define LATCH_BANK_BYPASS_EN to forward accepted write data straight to q on a read hit.
module latch_bank
    import latch_bank_pkg::*;
#(
    parameter  int unsigned WIDTH = DefWidth,
    parameter  int unsigned NCH   = DefNch,
    localparam int unsigned AW    = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [AW-1:0]    wr_ch,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_req,
    input  logic [AW-1:0]    rd_ch,
    output logic [WIDTH-1:0] q,
    output logic [NCH-1:0]   chg,
    input  logic [NCH-1:0]   chg_clr,
    output logic             busy
);

    localparam logic [AW:0]   NchW    = (AW+1)'(NCH);
    localparam logic [AW-1:0] LastPtr = AW'(NCH - 1);

    state_e           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [NCH-1:0]   chg_q, chg_d;
    logic [NCH-1:0]   cell_ld, cell_clr;
    logic [WIDTH-1:0] cell_q [NCH];
    logic             wr_acc, wr_in_range, sweep_clr, bypass;

    assign wr_rdy      = (state_q == StIdle) && en;
    assign wr_acc      = wr_vld && wr_rdy;
    assign wr_in_range = {1'b0, wr_ch} < NchW;
    assign sweep_clr   = (state_q == StClear) && en;
    assign busy        = (state_q == StClear);
    assign chg         = chg_q;

`ifdef LATCH_BANK_BYPASS_EN
    assign bypass = wr_acc && wr_in_range && (wr_ch == rd_ch);
`else
    assign bypass = 1'b0;
`endif

    // en=0 leaves state and ptr untouched, which pauses a sweep in place.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (en && clr_req) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end
            end
            StClear: begin
                if (en) begin
                    if (ptr_q == LastPtr) begin
                        state_d = StIdle;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Set beats clear on chg; the sweep never touches chg.
    always_comb begin
        cell_ld  = '0;
        cell_clr = '0;
        chg_d    = '0;
        for (int i = 0; i < NCH; i++) begin
            cell_ld[i]  = wr_acc && wr_in_range && (wr_ch == AW'(i));
            cell_clr[i] = sweep_clr && (ptr_q == AW'(i));
            chg_d[i]    = (cell_ld[i] && (d != cell_q[i])) || (chg_q[i] && !chg_clr[i]);
        end
    end

    always_comb begin
        q = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_ch == AW'(i)) begin
                q = cell_q[i];
            end
        end
        if (bypass) begin
            q = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            chg_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            chg_q   <= chg_d;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_cell
        latch_bank_cell #(
            .WIDTH(WIDTH)
        ) u_cell (
            .clk(clk),
            .rst(rst),
            .ld (cell_ld[g]),
            .clr(cell_clr[g]),
            .d  (d),
            .q  (cell_q[g])
        );
    end

endmodule

// File: tb/tb_latch_bank.sv
// Scoreboard bench for latch_bank at WIDTH=8, NCH=4; honours LATCH_BANK_BYPASS_EN.
module tb_latch_bank;

    logic       clk = 1'b0;
    logic       rst, en, wr_vld, wr_rdy, clr_req, busy;
    logic [1:0] wr_ch, rd_ch;
    logic [7:0] d, q;
    logic [3:0] chg, chg_clr;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    latch_bank #(
        .WIDTH(8),
        .NCH  (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .wr_vld (wr_vld),
        .wr_rdy (wr_rdy),
        .wr_ch  (wr_ch),
        .d      (d),
        .clr_req(clr_req),
        .rd_ch  (rd_ch),
        .q      (q),
        .chg    (chg),
        .chg_clr(chg_clr),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() == 0) begin
            check_eq("sb_underflow", 1, 0);
        end else begin
            e = sb.pop_front();
            check_eq(e.tag, q, e.val);
        end
    endtask

    // Inputs change 1 after the edge; outputs are sampled 3 after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [7:0] v);
        wr_vld = 1'b1;
        wr_ch  = ch;
        d      = v;
        step();
        wr_vld = 1'b0;
        settle();
    endtask

    task automatic read_exp(input string tag, input logic [1:0] ch, input logic [7:0] v);
        rd_ch = ch;
        push_exp(tag, v);
        settle();
        pop_cmp();
    endtask

    initial begin
        int cnt;
        rst = 1'b1; en = 1'b0; wr_vld = 1'b0; wr_ch = '0; d = '0;
        clr_req = 1'b0; rd_ch = '0; chg_clr = '0;
        step();
        rst = 1'b0;
        en  = 1'b1;
        settle();
        check_eq("rst_q", q, 8'h00);
        check_eq("rst_chg", chg, 4'b0000);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_wr_rdy", wr_rdy, 1'b1);

        // Write ch2, change flag set, identical rewrite, W1C, then set-wins-over-clear.
        rd_ch = 2'd2;
        push_exp("wr_ch2_a5", 8'hA5);
        wr(2'd2, 8'hA5);
        pop_cmp();
        check_eq("chg_set", chg, 4'b0100);
        chg_clr = 4'b0100;
        step();
        chg_clr = '0;
        settle();
        check_eq("chg_w1c", chg, 4'b0000);
        wr(2'd2, 8'hA5);
        check_eq("chg_same_data", chg, 4'b0000);
        chg_clr = 4'b0100;
        push_exp("wr_ch2_5a", 8'h5A);
        wr(2'd2, 8'h5A);
        chg_clr = '0;
        pop_cmp();
        check_eq("chg_set_wins", chg, 4'b0100);

        // en=0 blocks the write but chg_clr still acts.
        en = 1'b0; rd_ch = 2'd1; chg_clr = 4'b0100;
        wr_vld = 1'b1; wr_ch = 2'd1; d = 8'h3C;
        settle();
        check_eq("en0_wr_rdy", wr_rdy, 1'b0);
        step();
        chg_clr = '0;
        settle();
        check_eq("en0_hold_q", q, 8'h00);
        check_eq("en0_chg_clr", chg, 4'b0000);
        en = 1'b1;
        settle();
        check_eq("en1_wr_rdy", wr_rdy, 1'b1);
        push_exp("en1_wr_ch1", 8'h3C);
        step();
        wr_vld = 1'b0;
        settle();
        pop_cmp();
        check_eq("en1_chg", chg, 4'b0010);

        // Full sweep of 4 enabled cycles; chg must survive it.
        for (int i = 0; i < 4; i++) wr(2'(i), 8'(8'h11 * (i + 1)));
        for (int i = 0; i < 4; i++) read_exp("pre_sweep", 2'(i), 8'(8'h11 * (i + 1)));
        check_eq("pre_sweep_chg", chg, 4'b1111);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        settle();
        check_eq("sweep_wr_rdy", wr_rdy, 1'b0);
        cnt = 0;
        while (busy && cnt < 20) begin
            step();
            settle();
            cnt++;
        end
        check_eq("sweep_len", 32'(cnt), 4);
        for (int i = 0; i < 4; i++) read_exp("post_sweep", 2'(i), 8'h00);
        check_eq("post_sweep_chg", chg, 4'b1111);

        // Pause 2 cycles mid-sweep; clr_req during pause must not restart it.
        for (int i = 0; i < 4; i++) wr(2'(i), 8'(i + 1));
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        settle();
        cnt = 0;
        while (busy && cnt < 20) begin
            if (cnt == 2) en = 1'b0;
            if (cnt == 3) begin
                clr_req = 1'b1;
                read_exp("pause_hold_ch2", 2'd2, 8'h03);
            end
            if (cnt == 4) begin
                en      = 1'b1;
                clr_req = 1'b0;
            end
            step();
            settle();
            cnt++;
        end
        check_eq("pause_sweep_len", 32'(cnt), 6);

        // Reset aborts a sweep and zeroes channels it has not reached.
        wr(2'd3, 8'h55);
        chg_clr = 4'b1111;
        step();
        chg_clr = '0;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        settle();
        check_eq("mid_busy", busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_chg", chg, 4'b0000);
        for (int i = 0; i < 4; i++) read_exp("abort_zero", 2'(i), 8'h00);

        // Read-during-write on ch3.
        rd_ch = 2'd3; wr_vld = 1'b1; wr_ch = 2'd3; d = 8'h7E;
        settle();
`ifdef LATCH_BANK_BYPASS_EN
        check_eq("rdw_same_cycle", q, 8'h7E);
`else
        check_eq("rdw_same_cycle", q, 8'h00);
`endif
        push_exp("rdw_next_cycle", 8'h7E);
        step();
        wr_vld = 1'b0;
        settle();
        pop_cmp();

        check_eq("sb_drain", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
